inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction fetch stage directly upstream of the Control decode modules; owns the fetch PC.
- Issues word reads to instruction memory over a req/ack handshake and buffers returned words with their PCs in a small prefetch FIFO.
- Presents instructions to decode via valid/ready. Decode or the datapath can redirect the stream; a redirect flushes the FIFO and discards any stale in-flight response.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req is high.
- imem_ack  in  1  read completes at a rising edge where imem_req && imem_ack.
- imem_rdata  in  32  instruction word; valid in the ack cycle.
- redirect  in  1  one-cycle pulse requesting a PC change (branch/jump).
- redirect_pc  in  32  new PC; bits [1:0] are forced to 0.
- inst  out  32  FIFO head instruction.
- inst_pc  out  32  PC of the FIFO head.
- inst_valid  out  1  FIFO non-empty.
- inst_ready  in  1  decode accepts the head; a pop occurs when inst_valid && inst_ready.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst low, asynchronous):
  - fetch_pc = RESET_PC; FIFO empty; state = IDLE.
  - imem_req = 0; imem_addr = RESET_PC; inst = 0; inst_pc = 0; inst_valid = 0; fifo_level = 0.
  - Reset mid-transaction abandons it; the memory must tolerate req dropping.
- States:
  - IDLE: no request outstanding. If no redirect and level + 0 < DEPTH, raise imem_req with imem_addr = fetch_pc and go to REQ.
  - REQ: hold imem_req and imem_addr until ack.
    - On ack: push {imem_rdata, imem_addr}, set fetch_pc += 4 (wraps modulo 2^32), and go to IDLE.
    - Back-to-back: if the FIFO will still have space after this cycle's push and pop, stay in REQ with imem_addr = fetch_pc + 4.
  - DROP: a redirect occurred while REQ was pending. imem_req and the old address are held until ack; that ack's data is discarded (no push); then go to IDLE.
- Redirect, in any state, at the edge where redirect = 1:
  - FIFO flushed (level 0, inst_valid 0 next cycle); fetch_pc = {redirect_pc[31:2], 2'b00}.
  - REQ without ack in the same cycle -> DROP.
  - REQ with ack in the same cycle -> the word is discarded, go to IDLE.
  - DROP -> stay in DROP (the newer redirect_pc wins).
  - No request is issued in the redirect cycle itself.
- Redirect and pop in the same cycle: the redirect wins. The pop is still counted as taken by decode, but nothing remains.
- Full: no new request is issued when level == DEPTH. A push and a pop at the same edge while full is legal; level stays at DEPTH.
- Empty: inst_valid = 0; inst and inst_pc hold their last values (don't-care).
- Latency:
  - Zero-wait memory (ack in the first req cycle): redirect at edge N -> req at N+1 -> inst_valid at N+2.
  - Sustained throughput: 1 instruction/cycle with a zero-wait memory.
- Ordering: instructions are delivered in fetch order. No instruction with a PC from before a redirect is ever delivered after that redirect.

Optional Feature:
- FETCH_STATS_EN defined: adds two outputs, stat_fetch_cnt[31:0] and stat_flush_cnt[31:0], both reset to 0 and wrapping.
  - stat_fetch_cnt: +1 per completed memory read, including dropped ones.
  - stat_flush_cnt: +1 per redirect pulse.
- Not defined: these ports and counters are absent.

Test Plan:
- Reset release, zero-wait memory returning addr as data, inst_ready = 1 -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; inst/inst_pc pairs (0x0, 0x0), (0x4, 0x4), in order, one per cycle after 2-cycle latency.
- inst_ready = 0, zero-wait memory, DEPTH = 4 -> exactly 4 reads; fifo_level = 4; imem_req = 0 thereafter. Raising inst_ready pops PCs 0x0..0xC, then fetching resumes at 0x10.
- Memory with 3-cycle ack; redirect to 0x103 asserted while the read of 0x8 is pending -> imem_addr holds 0x8 until ack; that data is never output; next imem_addr = 0x100; first inst_pc = 0x100.
- Redirect to 0x200 in the same cycle as a pop and an ack -> fifo_level = 0 next cycle; no PC below 0x200 appears afterwards.
- fetch_pc near the top (redirect to 0xFFFF_FFFC) -> fetches 0xFFFF_FFFC then 0x0000_0000.
- Pull rst low while in REQ -> imem_req = 0, inst_valid = 0, fifo_level = 0 immediately. After release, the first imem_addr is RESET_PC. With FETCH_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage sitting directly upstream of the decode logic. It
// owns the fetch PC, issues word reads to instruction memory over a req/ack
// handshake, buffers returned words (with their PCs) in a small prefetch FIFO
// and hands them to decode over valid/ready. A redirect flushes the FIFO and
// makes sure any read already in flight is thrown away when it returns.
//
// Parameters:
//   DEPTH     prefetch FIFO entries (power of two, >= 2)
//   RESET_PC  fetch PC loaded on reset
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   imem_req     read request to instruction memory
//   imem_addr    word-aligned fetch address, stable while imem_req is high
//   imem_ack     read completes on an edge where imem_req && imem_ack
//   imem_rdata   instruction word, valid in the ack cycle
//   redirect     one-cycle pulse requesting a PC change
//   redirect_pc  new PC (bits [1:0] ignored)
//   inst         FIFO head instruction
//   inst_pc      PC of the FIFO head
//   inst_valid   FIFO non-empty
//   inst_ready   decode accepts the head (pop on inst_valid && inst_ready)
//   fifo_level   current FIFO occupancy
//
// Optional build macro FETCH_STATS_EN adds two free-running wrap-around
// counters: stat_fetch_cnt (completed memory reads, dropped ones included)
// and stat_flush_cnt (redirect pulses).
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]              stat_fetch_cnt,
  output logic [31:0]              stat_flush_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          r_state;
  logic [31:0]     r_fetch_pc;
  logic            r_req;
  logic [31:0]     r_addr;

  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [31:0]     r_mem_inst [DEPTH];
  logic [31:0]     r_mem_pc   [DEPTH];

  logic            w_ack;
  logic            w_push;
  logic            w_pop;
  logic [LW-1:0]   w_level_after;
  logic [31:0]     w_fetch_pc_inc;
  logic [31:0]     w_redirect_pc;
  logic            w_unused;

  // Low address bits of a redirect target are ignored by design.
  assign w_unused = ^redirect_pc[1:0];

  assign w_ack          = r_req && imem_ack;
  // Only a live read (not one being dropped) may land in the FIFO, and a
  // redirect in the same cycle discards it as well.
  assign w_push         = w_ack && (r_state == REQ) && !redirect;
  assign w_pop          = inst_valid && inst_ready;
  assign w_level_after  = r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
  assign w_fetch_pc_inc = r_fetch_pc + 32'd4;
  assign w_redirect_pc  = {redirect_pc[31:2], 2'b00};

  assign imem_req   = r_req;
  assign imem_addr  = r_addr;
  assign inst_valid = (r_level != '0);
  assign fifo_level = r_level;
  assign inst       = r_mem_inst[r_rd_ptr];
  assign inst_pc    = r_mem_pc[r_rd_ptr];

  // ---------------------------------------------------------------------------
  // Fetch FSM. In REQ the outstanding address always equals r_fetch_pc; in
  // IDLE r_fetch_pc is the next address to fetch.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
    end else if (redirect) begin
      r_fetch_pc <= w_redirect_pc;
      case (r_state)
        REQ, DROP: begin
          if (imem_ack) begin
            // The read completes this edge; its data is simply not pushed.
            r_req   <= 1'b0;
            r_state <= IDLE;
          end else begin
            // The memory still owes us a response to the old address: keep
            // req/addr stable and swallow the response when it arrives.
            r_state <= DROP;
          end
        end
        default: begin
          // No request is launched in the redirect cycle itself.
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end else begin
      case (r_state)
        IDLE: begin
          if (r_level < DEPTH_L) begin
            r_req   <= 1'b1;
            r_addr  <= r_fetch_pc;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (imem_ack) begin
            r_fetch_pc <= w_fetch_pc_inc;
            // Chain the next read only if the response is guaranteed a slot.
            if (w_level_after < DEPTH_L) begin
              r_addr <= w_fetch_pc_inc;
            end else begin
              r_req   <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        DROP: begin
          if (imem_ack) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO pointers and occupancy. Pointers wrap naturally because
  // DEPTH is a power of two.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (redirect) begin
      // Flush wins over any push or pop in the same cycle.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= w_level_after;
    end
  end

  // FIFO storage: one register pair per entry so the head is readable
  // combinationally and clears to zero on reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_mem_inst[gi] <= '0;
          r_mem_pc[gi]   <= '0;
        end else if (w_push && (r_wr_ptr == AW'(gi))) begin
          r_mem_inst[gi] <= imem_rdata;
          r_mem_pc[gi]   <= r_addr;
        end
      end
    end
  endgenerate

`ifdef FETCH_STATS_EN
  logic [31:0] r_stat_fetch_cnt;
  logic [31:0] r_stat_flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_fetch_cnt <= '0;
      r_stat_flush_cnt <= '0;
    end else begin
      // Every completed handshake counts, including discarded responses.
      if (w_ack) begin
        r_stat_fetch_cnt <= r_stat_fetch_cnt + 32'd1;
      end
      if (redirect) begin
        r_stat_flush_cnt <= r_stat_flush_cnt + 32'd1;
      end
    end
  end

  assign stat_fetch_cnt = r_stat_fetch_cnt;
  assign stat_flush_cnt = r_stat_flush_cnt;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Directed testbench for inst_fetch (DEPTH = 4, RESET_PC = 0). A small
// instruction memory model answers reads after a programmable number of wait
// cycles with data = address ^ mem_xor. Every pop and every completed read is
// logged so delivery order and fetch addresses can be checked.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [2:0]  fifo_level;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetch_cnt;
  logic [31:0] stat_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // memory model
  int          mem_lat = 0;
  logic [31:0] mem_xor = 32'h0;
  int          mem_cnt = 0;

  logic [31:0] q_pop_pc[$];
  logic [31:0] q_pop_inst[$];
  logic [31:0] q_reads[$];

  inst_fetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .fifo_level  (fifo_level)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetch_cnt (stat_fetch_cnt),
    .stat_flush_cnt (stat_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ack arrives in cycle (mem_lat + 1) of a request
  always @(posedge clk) begin
    if (imem_req && !imem_ack) mem_cnt <= mem_cnt + 1;
    else                       mem_cnt <= 0;
  end
  assign imem_ack   = imem_req && (mem_cnt == mem_lat);
  assign imem_rdata = imem_addr ^ mem_xor;

  // Log what happens at the coming edge, then advance to just after it.
  task automatic tick();
    if (inst_valid && inst_ready) begin
      q_pop_pc.push_back(inst_pc);
      q_pop_inst.push_back(inst);
    end
    if (imem_req && imem_ack) q_reads.push_back(imem_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    q_pop_pc.delete();
    q_pop_inst.delete();
    q_reads.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    tick();
    tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL reset_inst: got %h want 00000000", inst); end
    total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL reset_inst_pc: got %h want 00000000", inst_pc); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
`ifdef FETCH_STATS_EN
    total++; if (stat_fetch_cnt !== 32'd0) begin bad++; $display("FAIL reset_stat_fetch: got %0d want 0", stat_fetch_cnt); end
    total++; if (stat_flush_cnt !== 32'd0) begin bad++; $display("FAIL reset_stat_flush: got %0d want 0", stat_flush_cnt); end
`endif
    $display("test_reset: outputs idle after reset");
  endtask

  task automatic test_stream();
    mem_lat = 0; mem_xor = 32'h0; inst_ready = 1'b1;
    rst = 1'b1;
    clear_logs();
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL stream_first_req: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
    tick();
    total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL stream_addr1: got %h want 00000004", imem_addr); end
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h0) begin bad++; $display("FAIL stream_head0: got v=%b pc=%h inst=%h want v=1 pc=00000000 inst=00000000", inst_valid, inst_pc, inst); end
    tick();
    total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL stream_addr2: got %h want 00000008", imem_addr); end
    total++; if (inst_pc !== 32'h4 || inst !== 32'h4) begin bad++; $display("FAIL stream_head1: got pc=%h inst=%h want pc=00000004 inst=00000004", inst_pc, inst); end
    repeat (5) tick();
    total++; if (q_pop_pc.size() != 6) begin bad++; $display("FAIL stream_pop_count: got %0d want 6", q_pop_pc.size()); end
    for (int k = 0; k < q_pop_pc.size(); k++) begin
      total++;
      if (q_pop_pc[k] !== 32'(4 * k) || q_pop_inst[k] !== 32'(4 * k)) begin
        bad++; $display("FAIL stream_pop%0d: got pc=%h inst=%h want %h", k, q_pop_pc[k], q_pop_inst[k], 32'(4 * k));
      end
    end
    $display("test_stream: %0d instructions delivered", q_pop_pc.size());
  endtask

  task automatic test_full();
    mem_lat = 0; mem_xor = 32'hDEAD_0000; inst_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    total++; if (q_reads.size() != 4) begin bad++; $display("FAIL full_read_count: got %0d want 4", q_reads.size()); end
    for (int k = 0; k < 4 && k < q_reads.size(); k++) begin
      total++; if (q_reads[k] !== 32'(4 * k)) begin bad++; $display("FAIL full_read%0d: got %h want %h", k, q_reads[k], 32'(4 * k)); end
    end
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL full_level: got %0d want 4", fifo_level); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL full_req_idle: got %b want 0", imem_req); end
    total++; if (q_pop_pc.size() != 0) begin bad++; $display("FAIL full_no_pop: got %0d want 0", q_pop_pc.size()); end
    clear_logs();
    inst_ready = 1'b1;
    repeat (8) tick();
    total++; if (q_pop_pc.size() < 5) begin bad++; $display("FAIL full_drain_count: got %0d want >=5", q_pop_pc.size()); end
    for (int k = 0; k < 5 && k < q_pop_pc.size(); k++) begin
      total++;
      if (q_pop_pc[k] !== 32'(4 * k) || q_pop_inst[k] !== (32'(4 * k) ^ 32'hDEAD_0000)) begin
        bad++; $display("FAIL full_drain%0d: got pc=%h inst=%h want pc=%h", k, q_pop_pc[k], q_pop_inst[k], 32'(4 * k));
      end
    end
    total++; if (q_reads.size() == 0 || q_reads[0] !== 32'h10) begin bad++; $display("FAIL full_resume_addr: got %h want 00000010", (q_reads.size() > 0) ? q_reads[0] : 32'hx); end
    $display("test_full: filled to 4, drained and resumed");
  endtask

  task automatic test_redirect_drop();
    int found;
    mem_lat = 2; mem_xor = 32'hDEAD_0000; inst_ready = 1'b1;
    do_reset();
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req && imem_addr == 32'h8) begin found = 1; break; end
      tick();
    end
    total++; if (found != 1 || imem_ack !== 1'b0) begin bad++; $display("FAIL drop_find_pending: got found=%0d ack=%b want found=1 ack=0", found, imem_ack); end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    clear_logs();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL drop_hold: got req=%b addr=%h want req=1 addr=00000008", imem_req, imem_addr); end
    total++; if (fifo_level !== 3'd0 || inst_valid !== 1'b0) begin bad++; $display("FAIL drop_flush: got level=%0d v=%b want 0 0", fifo_level, inst_valid); end
    for (int i = 0; i < 10 && q_reads.size() == 0; i++) begin
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL drop_hold_cycle: got req=%b addr=%h want req=1 addr=00000008", imem_req, imem_addr); end
      tick();
    end
    total++; if (q_reads.size() != 1 || q_reads[0] !== 32'h8) begin bad++; $display("FAIL drop_ack: got n=%0d want one read of 00000008", q_reads.size()); end
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) begin found = 1; break; end
      tick();
    end
    total++; if (found != 1 || imem_addr !== 32'h100) begin bad++; $display("FAIL drop_next_addr: got found=%0d addr=%h want 00000100", found, imem_addr); end
    for (int i = 0; i < 20 && q_pop_pc.size() == 0; i++) tick();
    total++;
    if (q_pop_pc.size() == 0 || q_pop_pc[0] !== 32'h100 || q_pop_inst[0] !== 32'hDEAD_0100) begin
      bad++; $display("FAIL drop_first_inst: got n=%0d pc=%h want pc=00000100 inst=dead0100", q_pop_pc.size(), (q_pop_pc.size() > 0) ? q_pop_pc[0] : 32'hx);
    end
    $display("test_redirect_drop: stale read discarded, restarted at 0x100");
  endtask

  task automatic test_redirect_pop_ack();
    mem_lat = 0; mem_xor = 32'hDEAD_0000; inst_ready = 1'b1;
    do_reset();
    repeat (5) tick();
    total++; if (imem_ack !== 1'b1 || inst_valid !== 1'b1) begin bad++; $display("FAIL rpa_setup: got ack=%b valid=%b want 1 1", imem_ack, inst_valid); end
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    clear_logs();
    total++; if (fifo_level !== 3'd0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rpa_flush: got level=%0d v=%b want 0 0", fifo_level, inst_valid); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rpa_no_req: got %b want 0", imem_req); end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin bad++; $display("FAIL rpa_req: got req=%b addr=%h want req=1 addr=00000200", imem_req, imem_addr); end
    tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin bad++; $display("FAIL rpa_valid: got v=%b pc=%h want v=1 pc=00000200", inst_valid, inst_pc); end
    repeat (4) tick();
    total++; if (q_pop_pc.size() != 4) begin bad++; $display("FAIL rpa_pop_count: got %0d want 4", q_pop_pc.size()); end
    for (int k = 0; k < q_pop_pc.size(); k++) begin
      total++; if (q_pop_pc[k] !== (32'h200 + 32'(4 * k))) begin bad++; $display("FAIL rpa_pop%0d: got %h want %h", k, q_pop_pc[k], 32'h200 + 32'(4 * k)); end
    end
    $display("test_redirect_pop_ack: flush with pop and ack, resumed at 0x200");
  endtask

  task automatic test_wrap();
    mem_lat = 0; mem_xor = 32'hDEAD_0000; inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    clear_logs();
`ifdef FETCH_STATS_EN
    total++; if (stat_flush_cnt !== 32'd2) begin bad++; $display("FAIL wrap_stat_flush: got %0d want 2", stat_flush_cnt); end
`endif
    repeat (6) tick();
    total++; if (q_reads.size() < 3 || q_reads[0] !== 32'hFFFF_FFFC || q_reads[1] !== 32'h0 || q_reads[2] !== 32'h4) begin
      bad++; $display("FAIL wrap_reads: got n=%0d r0=%h r1=%h want fffffffc 00000000 00000004", q_reads.size(),
        (q_reads.size() > 0) ? q_reads[0] : 32'hx, (q_reads.size() > 1) ? q_reads[1] : 32'hx);
    end
    total++; if (q_pop_pc.size() < 2 || q_pop_pc[0] !== 32'hFFFF_FFFC || q_pop_inst[0] !== 32'h2152_FFFC || q_pop_pc[1] !== 32'h0) begin
      bad++; $display("FAIL wrap_pops: got n=%0d pc0=%h inst0=%h want pc0=fffffffc inst0=2152fffc pc1=00000000", q_pop_pc.size(),
        (q_pop_pc.size() > 0) ? q_pop_pc[0] : 32'hx, (q_pop_inst.size() > 0) ? q_pop_inst[0] : 32'hx);
    end
    $display("test_wrap: fetch wrapped from 0xfffffffc to 0x0");
  endtask

  task automatic test_reset_mid();
    int found;
    mem_lat = 2; inst_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (fifo_level >= 3'd1 && imem_req && !imem_ack) begin found = 1; break; end
      tick();
    end
    total++; if (found != 1) begin bad++; $display("FAIL rmid_setup: got found=%0d want 1", found); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rmid_req: got %b want 0", imem_req); end
    total++; if (inst_valid !== 1'b0 || fifo_level !== 3'd0) begin bad++; $display("FAIL rmid_fifo: got v=%b level=%0d want 0 0", inst_valid, fifo_level); end
    total++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin bad++; $display("FAIL rmid_head: got inst=%h pc=%h want 0 0", inst, inst_pc); end
`ifdef FETCH_STATS_EN
    total++; if (stat_fetch_cnt !== 32'd0 || stat_flush_cnt !== 32'd0) begin bad++; $display("FAIL rmid_stats: got fetch=%0d flush=%0d want 0 0", stat_fetch_cnt, stat_flush_cnt); end
`endif
    tick();
    tick();
    rst = 1'b1;
    clear_logs();
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) begin found = 1; break; end
      tick();
    end
    total++; if (found != 1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rmid_first_addr: got found=%0d addr=%h want 00000000", found, imem_addr); end
    $display("test_reset_mid: async reset abandoned pending read");
  endtask

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_redirect_drop();
    test_redirect_pop_ack();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
